fork_waiter: RTL and testbench
==============================

# fork_waiter

Central waiter for an N-seat dining-philosophers ring. Each seat raises a hungry request, and the waiter grants eating rights only when both adjacent forks are free, so fork pairs are always taken atomically and deadlock cannot occur. Grants use a round-robin scan with a concurrency cap and an aging override that bounds starvation. The block sits beside the philosopher ring: seat state drives `req`/`rel`, and `eat` gates the EATING transition.

## Interface
- `N`, 8: number of seats/forks; N >= 3.
- `MAX_EATERS`, 4: maximum simultaneous eaters; 1 <= MAX_EATERS <= N/2.
- `AGE_MAX`, 15: wait-counter saturation value and starvation threshold; >= 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  level, seat i is hungry.
- `rel`  in  N  pulse, seat i finishes eating.
- `eat`  out  N  registered grant, seat i holds forks i and (i+1)%N.
- `starved`  out  N  registered, `wait_cnt[i] == AGE_MAX`.
- `eat_cnt`  out  $clog2(N+1)  registered population count of `eat`.

## Operation
- **Ring topology.** Seat i uses fork i (left) and fork (i+1)%N (right). Its neighbours are (i-1)%N and (i+1)%N.
- **State.**
  - `eat[N]`
  - `ptr` (log2 N bits, scan start)
  - `wait_cnt[i]`, width $clog2(AGE_MAX+1)
- **Eligibility** at an edge: `req[i] & ~eat[i] & ~eat[i-1] & ~eat[i+1]`, evaluated on registered `eat` only. Forks released at this edge are not reusable at this edge.
- **Scan start.** If any `starved[i]` is set, start at the lowest-index starved seat; otherwise start at `ptr`.
- **Scan.** Visit N seats in ascending ring order from the start. Grant seat i if all of the following hold:
  - it is eligible;
  - neither neighbour was granted earlier in this scan;
  - `eat_cnt` minus releases this edge plus grants so far is < MAX_EATERS.
- **Release.** If `rel[i] & eat[i]`, clear `eat[i]`. `rel[i]` with `eat[i]=0` is ignored.
- **Grant hold.** A granted seat stays `eat[i]=1` until released, regardless of `req[i]`. `req[i]` while eating is ignored.
- **Pointer.** If at least one grant is made, `ptr <= (index of last grant in scan order + 1) % N`. Otherwise `ptr` holds.
- **Wait counter.**
  - Increment, saturating at AGE_MAX, if `req[i] & ~eat[i]` and seat i is not granted this edge.
  - Clear if `req[i]=0` or seat i is granted or eating.
- `starved` and `eat_cnt` are registered alongside `eat` and reflect post-edge state.
- **Invariant** (assert in bench): no two adjacent bits of `eat` are set, and `eat_cnt <= MAX_EATERS`.

## Timing
- **Reset.** While `rst_n=0`, immediately and without a clock edge: `eat=0`, `starved=0`, `eat_cnt=0`, `ptr=0`, all `wait_cnt=0`. Reset asserted mid-meal drops all grants; no release is required afterwards.
- **Grant latency.** `req` sampled high at edge t with the seat eligible gives `eat` high after edge t (1 cycle).
- **Release latency.** `rel` sampled at edge t clears `eat` after edge t. The freed forks are grantable at edge t+1 at the earliest.
- **Simultaneous release and request** by a neighbour at the same edge: the neighbour is not granted until the next edge.
- **Simultaneous release and own request**: seat i releases. It can be re-granted at t+1 only if it wins that scan.
- **Starvation.** `starved[i]` rises after AGE_MAX consecutive ungranted hungry edges. It falls on the edge where seat i is granted or `req[i]` drops.
- **Pointer wrap.** `ptr` wraps from N-1 to 0. The scan wraps likewise.

## Test plan
1. **Full request.** Reset, then hold `req=8'hFF` from idle. One edge later: `eat=8'h55`, `eat_cnt=4`, `ptr=7`. At the following edges `wait_cnt` of seats 1, 3, 5, 7 increments.
2. **Conflict and ignored release.** From idle, `req=8'h03` gives `eat=8'h01`, `ptr=1`. Pulse `rel=8'h02`: no change. Pulse `rel=8'h01`: `eat=8'h00` after that edge, and seat 1 is granted (`eat=8'h02`) at the next edge.
3. **Concurrency cap.** Instance with MAX_EATERS=2, `req=8'hFF` from idle gives `eat=8'h05`, `eat_cnt=2`, `ptr=3`.
4. **Aging override.** AGE_MAX=3, `req=8'h07` from idle.
   - Edge 1: `eat=8'h05`, `ptr=3`.
   - `starved[1]=1` after edge 3.
   - Pulse `rel=8'h05` with `req` held: `eat=8'h00`, then at the next edge `eat=8'h02` (without aging the result would be `8'h05`) and `starved[1]` clears.
5. **Async reset mid-operation.** With `eat=8'h55`, drive `rst_n=0` between clock edges. `eat`, `eat_cnt` and `starved` go to 0 before the next edge. After release, `req=8'hFF` gives `eat=8'h55` again (`ptr` restarted at 0).
6. **Randomized.** Random `req`/`rel` for 10k cycles. Check the adjacency and cap invariants every cycle, and check that no hungry seat waits more than (AGE_MAX+1)·N edges.

Source files
------------

// File: rtl/fork_waiter_if.sv
// Bundle of the seat-side signals exchanged between the philosopher ring
// and the central fork waiter.
interface fork_waiter_if #(
  parameter int N = 8
) ();
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  req;
  logic [N-1:0]  rel;
  logic [N-1:0]  eat;
  logic [N-1:0]  starved;
  logic [CW-1:0] eat_cnt;

  // Ring side: raises hunger and release, watches the grants.
  modport master (
    output req,
    output rel,
    input  eat,
    input  starved,
    input  eat_cnt
  );

  // Waiter side: samples hunger and release, owns the grants.
  modport slave (
    input  req,
    input  rel,
    output eat,
    output starved,
    output eat_cnt
  );
endinterface

// File: rtl/fork_waiter.sv
// Central waiter for an N-seat dining-philosophers ring. Seat i eats with
// forks i and (i+1)%N; both forks are granted together so deadlock cannot
// occur. Grants come from a round-robin scan limited to MAX_EATERS eaters,
// and a seat hungry for AGE_MAX edges becomes starved and moves the scan
// start to itself.
module fork_waiter #(
  parameter int N          = 8,
  parameter int MAX_EATERS = 4,
  parameter int AGE_MAX    = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  fork_waiter_if.slave bus
);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int AW = $clog2(AGE_MAX + 1);

  logic [N-1:0]  eat_q, eat_d;
  logic [N-1:0]  starved_q, starved_d;
  logic [N-1:0]  grant;
  logic [N-1:0]  elig;
  logic [N-1:0]  rel_eff;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] start_idx;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] left_idx;
  logic [PW-1:0] right_idx;
  logic [PW-1:0] last_idx;
  logic [PW:0]   scan_sum;
  logic [CW:0]   active_cnt;
  logic [CW-1:0] eat_cnt_q, eat_cnt_d;
  logic [CW-1:0] rel_cnt;
  logic          any_grant;
  logic [AW-1:0] wait_cnt_q [N];
  logic [AW-1:0] wait_cnt_d [N];

  // Releases only count for seats actually eating; eligibility looks at the
  // registered grants so forks freed at this edge are not reused until the next.
  always_comb begin
    rel_eff = bus.rel & eat_q;
    rel_cnt = CW'($countones(rel_eff));
    elig    = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = bus.req[i] & ~eat_q[i] & ~eat_q[(i + N - 1) % N] & ~eat_q[(i + 1) % N];
    end
  end

  // Scan starts at the lowest-index starved seat, otherwise at the pointer.
  always_comb begin
    start_idx = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (starved_q[i]) begin
        start_idx = PW'(i);
      end
    end
  end

  // Round-robin scan: grant eligible seats whose neighbours were not already
  // granted in this scan while the eater count stays under the cap.
  always_comb begin
    grant      = '0;
    active_cnt = {1'b0, eat_cnt_q} - {1'b0, rel_cnt};
    last_idx   = ptr_q;
    any_grant  = 1'b0;
    scan_sum   = '0;
    scan_idx   = '0;
    left_idx   = '0;
    right_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_sum = {1'b0, start_idx} + (PW + 1)'(k);
      if (scan_sum >= (PW + 1)'(N)) begin
        scan_sum = scan_sum - (PW + 1)'(N);
      end
      scan_idx  = scan_sum[PW-1:0];
      left_idx  = (scan_idx == '0) ? PW'(N - 1) : scan_idx - PW'(1);
      right_idx = (scan_idx == PW'(N - 1)) ? '0 : scan_idx + PW'(1);
      if (elig[scan_idx] && !grant[left_idx] && !grant[right_idx] &&
          (active_cnt < (CW + 1)'(MAX_EATERS))) begin
        grant[scan_idx] = 1'b1;
        active_cnt      = active_cnt + (CW + 1)'(1);
        last_idx        = scan_idx;
        any_grant       = 1'b1;
      end
    end
  end

  // Next grants, pointer, per-seat wait ageing and the derived status outputs.
  always_comb begin
    eat_d     = (eat_q & ~rel_eff) | grant;
    eat_cnt_d = CW'($countones(eat_d));
    ptr_d     = ptr_q;
    if (any_grant) begin
      ptr_d = (last_idx == PW'(N - 1)) ? '0 : last_idx + PW'(1);
    end
    starved_d = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i] && !eat_q[i] && !grant[i]) begin
        wait_cnt_d[i] = (wait_cnt_q[i] == AW'(AGE_MAX)) ? wait_cnt_q[i]
                                                         : wait_cnt_q[i] + AW'(1);
      end else begin
        wait_cnt_d[i] = '0;
      end
      starved_d[i] = (wait_cnt_d[i] == AW'(AGE_MAX));
    end
  end

  // State registers; reset drops every grant and clears all ageing at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eat_q     <= '0;
      starved_q <= '0;
      eat_cnt_q <= '0;
      ptr_q     <= '0;
      for (int i = 0; i < N; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      eat_q     <= eat_d;
      starved_q <= starved_d;
      eat_cnt_q <= eat_cnt_d;
      ptr_q     <= ptr_d;
      for (int i = 0; i < N; i++) begin
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  assign bus.eat     = eat_q;
  assign bus.starved = starved_q;
  assign bus.eat_cnt = eat_cnt_q;

endmodule

// File: tb/tb_fork_waiter.sv
// Directed and randomized bench for fork_waiter using three instances:
// default (cap 4, age 15), cap 2, and age 3.
module tb_fork_waiter;
  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   check_cnt = 0;

  always #5 clk = ~clk;

  fork_waiter_if #(.N(8)) bus_a ();
  fork_waiter_if #(.N(8)) bus_b ();
  fork_waiter_if #(.N(8)) bus_c ();

  fork_waiter #(.N(8), .MAX_EATERS(4), .AGE_MAX(15)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  fork_waiter #(.N(8), .MAX_EATERS(2), .AGE_MAX(15)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  fork_waiter #(.N(8), .MAX_EATERS(4), .AGE_MAX(3))  dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  // Advance one rising edge and settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus_a.req = '0; bus_a.rel = '0;
    bus_b.req = '0; bus_b.rel = '0;
    bus_c.req = '0; bus_c.rel = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    #3;
    check_cnt++;
    if (bus_a.eat !== 8'h00) $display("[TB] FAIL reset_eat: got %h expected 00", bus_a.eat);
    else pass_cnt++;
    check_cnt++;
    if (bus_a.starved !== 8'h00) $display("[TB] FAIL reset_starved: got %h expected 00", bus_a.starved);
    else pass_cnt++;
    check_cnt++;
    if (bus_a.eat_cnt !== 4'd0) $display("[TB] FAIL reset_eat_cnt: got %0d expected 0", bus_a.eat_cnt);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_full_request();
    apply_reset();
    bus_a.req = 8'hFF;
    tick();
    check_cnt++;
    if (bus_a.eat !== 8'h55) $display("[TB] FAIL full_eat: got %h expected 55", bus_a.eat);
    else pass_cnt++;
    check_cnt++;
    if (bus_a.eat_cnt !== 4'd4) $display("[TB] FAIL full_eat_cnt: got %0d expected 4", bus_a.eat_cnt);
    else pass_cnt++;
    repeat (13) tick();
    check_cnt++;
    if (bus_a.starved !== 8'h00) $display("[TB] FAIL full_starved_edge14: got %h expected 00", bus_a.starved);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (bus_a.starved !== 8'hAA) $display("[TB] FAIL full_starved_edge15: got %h expected aa", bus_a.starved);
    else pass_cnt++;
    check_cnt++;
    if (bus_a.eat !== 8'h55) $display("[TB] FAIL full_eat_held: got %h expected 55", bus_a.eat);
    else pass_cnt++;
  endtask

  task automatic test_conflict();
    apply_reset();
    bus_a.req = 8'h03;
    tick();
    check_cnt++;
    if (bus_a.eat !== 8'h01) $display("[TB] FAIL conflict_grant: got %h expected 01", bus_a.eat);
    else pass_cnt++;
    bus_a.rel = 8'h02;
    tick();
    bus_a.rel = 8'h00;
    check_cnt++;
    if (bus_a.eat !== 8'h01) $display("[TB] FAIL conflict_ignored_rel: got %h expected 01", bus_a.eat);
    else pass_cnt++;
    bus_a.rel = 8'h01;
    tick();
    bus_a.rel = 8'h00;
    check_cnt++;
    if (bus_a.eat !== 8'h00) $display("[TB] FAIL conflict_release: got %h expected 00", bus_a.eat);
    else pass_cnt++;
    check_cnt++;
    if (bus_a.eat_cnt !== 4'd0) $display("[TB] FAIL conflict_release_cnt: got %0d expected 0", bus_a.eat_cnt);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (bus_a.eat !== 8'h02) $display("[TB] FAIL conflict_neighbour: got %h expected 02", bus_a.eat);
    else pass_cnt++;
  endtask

  task automatic test_cap();
    apply_reset();
    bus_b.req = 8'hFF;
    tick();
    check_cnt++;
    if (bus_b.eat !== 8'h05) $display("[TB] FAIL cap_eat: got %h expected 05", bus_b.eat);
    else pass_cnt++;
    check_cnt++;
    if (bus_b.eat_cnt !== 4'd2) $display("[TB] FAIL cap_eat_cnt: got %0d expected 2", bus_b.eat_cnt);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (bus_b.eat !== 8'h05) $display("[TB] FAIL cap_hold: got %h expected 05", bus_b.eat);
    else pass_cnt++;
    // Seat 0 leaves; its slot is reusable at the same edge, scan starts at 3.
    bus_b.rel = 8'h01;
    tick();
    bus_b.rel = 8'h00;
    check_cnt++;
    if (bus_b.eat !== 8'h14) $display("[TB] FAIL cap_refill: got %h expected 14", bus_b.eat);
    else pass_cnt++;
    check_cnt++;
    if (bus_b.eat_cnt !== 4'd2) $display("[TB] FAIL cap_refill_cnt: got %0d expected 2", bus_b.eat_cnt);
    else pass_cnt++;
  endtask

  task automatic test_aging();
    apply_reset();
    bus_c.req = 8'h07;
    tick();
    check_cnt++;
    if (bus_c.eat !== 8'h05) $display("[TB] FAIL aging_first: got %h expected 05", bus_c.eat);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (bus_c.starved !== 8'h00) $display("[TB] FAIL aging_edge2: got %h expected 00", bus_c.starved);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (bus_c.starved !== 8'h02) $display("[TB] FAIL aging_edge3: got %h expected 02", bus_c.starved);
    else pass_cnt++;
    bus_c.rel = 8'h05;
    tick();
    bus_c.rel = 8'h00;
    check_cnt++;
    if (bus_c.eat !== 8'h00) $display("[TB] FAIL aging_release: got %h expected 00", bus_c.eat);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (bus_c.eat !== 8'h02) $display("[TB] FAIL aging_override: got %h expected 02", bus_c.eat);
    else pass_cnt++;
    check_cnt++;
    if (bus_c.starved !== 8'h00) $display("[TB] FAIL aging_clear: got %h expected 00", bus_c.starved);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus_a.req = 8'hFF;
    tick();
    bus_a.rel = 8'h55;
    tick();
    bus_a.rel = 8'h00;
    check_cnt++;
    if (bus_a.eat !== 8'h00) $display("[TB] FAIL b2b_release: got %h expected 00", bus_a.eat);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (bus_a.eat !== 8'hAA) $display("[TB] FAIL b2b_wrap_scan: got %h expected aa", bus_a.eat);
    else pass_cnt++;
    bus_a.rel = 8'hAA;
    tick();
    bus_a.rel = 8'h00;
    tick();
    check_cnt++;
    if (bus_a.eat !== 8'h55) $display("[TB] FAIL b2b_second_wrap: got %h expected 55", bus_a.eat);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus_a.req = 8'hFF;
    repeat (15) tick();
    check_cnt++;
    if (bus_a.starved !== 8'hAA) $display("[TB] FAIL async_pre_starved: got %h expected aa", bus_a.starved);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (bus_a.eat !== 8'h00) $display("[TB] FAIL async_eat: got %h expected 00", bus_a.eat);
    else pass_cnt++;
    check_cnt++;
    if (bus_a.eat_cnt !== 4'd0) $display("[TB] FAIL async_eat_cnt: got %0d expected 0", bus_a.eat_cnt);
    else pass_cnt++;
    check_cnt++;
    if (bus_a.starved !== 8'h00) $display("[TB] FAIL async_starved: got %h expected 00", bus_a.starved);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    check_cnt++;
    if (bus_a.eat !== 8'h55) $display("[TB] FAIL async_restart: got %h expected 55", bus_a.eat);
    else pass_cnt++;
    check_cnt++;
    if (bus_a.eat_cnt !== 4'd4) $display("[TB] FAIL async_restart_cnt: got %0d expected 4", bus_a.eat_cnt);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] req_s [3];
    logic [7:0] eat_s [3];
    logic [3:0] cnt_s [3];
    int         cap_s [3];
    int         bound_s [3];
    int         age [3][8];
    int         worst;
    apply_reset();
    cap_s   = '{4, 2, 4};
    bound_s = '{16 * 8, 16 * 8, 4 * 8};
    for (int d = 0; d < 3; d++) begin
      req_s[d] = '0;
      for (int s = 0; s < 8; s++) age[d][s] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        req_s[d] = req_s[d] ^ 8'($urandom & $urandom & $urandom);
      end
      bus_a.req = req_s[0]; bus_a.rel = 8'($urandom | $urandom);
      bus_b.req = req_s[1]; bus_b.rel = 8'($urandom | $urandom);
      bus_c.req = req_s[2]; bus_c.rel = 8'($urandom | $urandom);
      tick();
      eat_s[0] = bus_a.eat; cnt_s[0] = bus_a.eat_cnt;
      eat_s[1] = bus_b.eat; cnt_s[1] = bus_b.eat_cnt;
      eat_s[2] = bus_c.eat; cnt_s[2] = bus_c.eat_cnt;
      for (int d = 0; d < 3; d++) begin
        check_cnt++;
        if ((eat_s[d] & {eat_s[d][0], eat_s[d][7:1]}) !== 8'h00)
          $display("[TB] FAIL rand_adjacent dut%0d cycle %0d: eat %h has neighbouring grants", d, cyc, eat_s[d]);
        else pass_cnt++;
        check_cnt++;
        if ((int'(cnt_s[d]) != $countones(eat_s[d])) || (int'(cnt_s[d]) > cap_s[d]))
          $display("[TB] FAIL rand_count dut%0d cycle %0d: eat_cnt %0d, required %0d and <= %0d",
                   d, cyc, cnt_s[d], $countones(eat_s[d]), cap_s[d]);
        else pass_cnt++;
        worst = 0;
        for (int s = 0; s < 8; s++) begin
          if (req_s[d][s] && !eat_s[d][s]) age[d][s] = age[d][s] + 1;
          else age[d][s] = 0;
          if (age[d][s] > worst) worst = age[d][s];
        end
        check_cnt++;
        if (worst > bound_s[d])
          $display("[TB] FAIL rand_starve dut%0d cycle %0d: wait %0d edges, limit %0d", d, cyc, worst, bound_s[d]);
        else pass_cnt++;
      end
    end
    drive_idle();
  endtask

  initial begin
    rst_n = 1'b1;
    drive_idle();
    #2;
    test_reset();
    test_full_request();
    test_conflict();
    test_cap();
    test_aging();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
